// File: rtl/note_event_capture_pkg.sv
// Shared types and constants for the note event capture path.
package note_event_capture_pkg;
  localparam int unsigned NOTES_PER_OCT   = 7;
  localparam int unsigned CODE_W          = 5;
  localparam int unsigned DUR_W           = 4;
  localparam int unsigned COUNT_W         = 7;
  localparam int unsigned TICK_CYCLES_DEF = 10_000_000;

  typedef logic [CODE_W-1:0]  code_t;
  typedef logic [DUR_W-1:0]   dur_t;
  typedef logic [COUNT_W-1:0] count_t;

  localparam code_t REST_CODE = '0;

  typedef enum logic [1:0] {
    OCT_LO = 2'd0,
    OCT_MI = 2'd1,
    OCT_HI = 2'd2
  } octave_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    code_t note;
    dur_t  dur;
  } ev_t;

  // A boundary inside the first tick still records one tick.
  function automatic dur_t dur_at_least_one(dur_t d);
    return (d == '0) ? dur_t'(1) : d;
  endfunction
endpackage

// File: rtl/note_event_capture_if.sv
// Key/octave inputs, live code and the event valid/ready port of the capture block.
interface note_event_capture_if;
  import note_event_capture_pkg::*;

  logic       en;
  logic       start;
  logic [7:0] sw;
  logic [1:0] octave;
  code_t      live_note;
  logic       ev_valid;
  code_t      ev_note;
  dur_t       ev_dur;
  logic       ev_ready;
  count_t     ev_count;
  logic       done;
  logic       overflow;

  modport slave (
    input  en, start, sw, octave, ev_ready,
    output live_note, ev_valid, ev_note, ev_dur, ev_count, done, overflow
  );

  modport master (
    output en, start, sw, octave, ev_ready,
    input  live_note, ev_valid, ev_note, ev_dur, ev_count, done, overflow
  );
endinterface

// File: rtl/note_event_capture_encode.sv
// Lowest pressed key plus octave to music code (1..21), 0 when no key is down.
module note_code_encode
  import note_event_capture_pkg::*;
(
  input  logic [NOTES_PER_OCT-1:0] keys,
  input  logic [1:0]               octave,
  output code_t                    code_c
);
  logic [2:0]  idx;
  logic        hit;
  int unsigned oct;

  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int i = int'(NOTES_PER_OCT) - 1; i >= 0; i--) begin
      if (keys[i]) begin
        idx = 3'(i);
        hit = 1'b1;
      end
    end
    // Octave value 3 is folded onto the middle octave.
    if (octave == OCT_LO)      oct = 0;
    else if (octave == OCT_HI) oct = 2;
    else                       oct = 1;
    code_c = hit ? CODE_W'(oct * NOTES_PER_OCT + 32'(idx) + 32'd1) : REST_CODE;
  end
endmodule

// File: rtl/note_event_capture.sv
// Turns held keys into (music code, duration) events on a valid/ready port.
module note_event_capture
  import note_event_capture_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = TICK_CYCLES_DEF,
  parameter int unsigned MAX_EVENTS  = 100,
  parameter int unsigned DUR_MAX     = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  note_event_capture_if.slave  bus
);
  localparam int unsigned DIV_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  state_e           state_q, state_d;
  code_t            code_c;
  code_t            cur_code_q, cur_code_d;
  code_t            live_note_q, live_note_d;
  dur_t             dur_q, dur_d;
  logic [DIV_W-1:0] div_q, div_d;
  ev_t              ev_q, ev_d;
  ev_t              emit_ev_c;
  logic             ev_valid_q, ev_valid_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;
  count_t           ev_count_q, ev_count_d;
  logic             tick_c, acc_c, emit_c, done_next_c;

  note_code_encode u_encode (
    .keys   (bus.sw[NOTES_PER_OCT-1:0]),
    .octave (bus.octave),
    .code_c (code_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cur_code_q  <= REST_CODE;
      live_note_q <= REST_CODE;
      dur_q       <= '0;
      div_q       <= '0;
      ev_q        <= '0;
      ev_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      ev_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_code_q  <= cur_code_d;
      live_note_q <= live_note_d;
      dur_q       <= dur_d;
      div_q       <= div_d;
      ev_q        <= ev_d;
      ev_valid_q  <= ev_valid_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      ev_count_q  <= ev_count_d;
    end
  end

  // Acceptance count; saturates so a late accept in DONE cannot clear done.
  always_comb begin
    acc_c      = ev_valid_q & bus.ev_ready;
    ev_count_d = ev_count_q;
    if (acc_c && (ev_count_q != COUNT_W'(MAX_EVENTS))) ev_count_d = ev_count_q + COUNT_W'(1);
    done_next_c = done_q | (ev_count_d == COUNT_W'(MAX_EVENTS));
    done_d      = done_next_c;
    if (bus.start) begin
      ev_count_d = '0;
      done_d     = 1'b0;
    end
  end

  // Tick divider, duration counter and segment FSM.
  always_comb begin
    state_d    = state_q;
    cur_code_d = cur_code_q;
    div_d      = '0;
    tick_c     = 1'b0;
    emit_c     = 1'b0;
    emit_ev_c  = '0;

    if (bus.en && (state_q == ST_HOLD || state_q == ST_GAP)) begin
      if (div_q == DIV_W'(TICK_CYCLES - 1)) tick_c = 1'b1;
      else                                  div_d  = div_q + DIV_W'(1);
    end
    dur_d = (tick_c && (dur_q != DUR_W'(DUR_MAX))) ? dur_q + DUR_W'(1) : dur_q;

    if (bus.en) begin
      unique case (state_q)
        ST_IDLE: if (code_c != REST_CODE) begin
          state_d    = ST_HOLD;
          cur_code_d = code_c;
          dur_d      = '0;
        end
        ST_HOLD: if (code_c != cur_code_q) begin
          emit_c         = 1'b1;
          emit_ev_c.note = cur_code_q;
          emit_ev_c.dur  = dur_at_least_one(dur_q);
          cur_code_d     = code_c;
          dur_d          = '0;
          div_d          = '0;
          if (code_c == REST_CODE) state_d = ST_GAP;
        end else if (tick_c && (dur_q == DUR_W'(DUR_MAX - 1))) begin
          emit_c         = 1'b1;
          emit_ev_c.note = cur_code_q;
          emit_ev_c.dur  = DUR_W'(DUR_MAX);
          dur_d          = '0;
        end
        ST_GAP: if (code_c != REST_CODE) begin
          // A gap shorter than one tick is absorbed into the next note.
          emit_c         = (dur_q != '0);
          emit_ev_c.note = REST_CODE;
          emit_ev_c.dur  = dur_q;
          state_d        = ST_HOLD;
          cur_code_d     = code_c;
          dur_d          = '0;
          div_d          = '0;
        end else if (tick_c && (dur_q == DUR_W'(DUR_MAX - 1))) begin
          emit_c         = 1'b1;
          emit_ev_c.note = REST_CODE;
          emit_ev_c.dur  = DUR_W'(DUR_MAX);
          state_d        = ST_IDLE;
          dur_d          = '0;
        end
        default: ;
      endcase
      if (done_next_c) state_d = ST_DONE;
    end

    if (bus.start) begin
      state_d = ST_IDLE;
      dur_d   = '0;
      div_d   = '0;
      emit_c  = 1'b0;
    end
  end

  // Event register: a new event while one is still unaccepted is dropped.
  always_comb begin
    ev_d        = ev_q;
    ev_valid_d  = ev_valid_q;
    overflow_d  = overflow_q;
    live_note_d = bus.en ? code_c : live_note_q;
    if (emit_c) begin
      if (ev_valid_q && !acc_c) begin
        overflow_d = 1'b1;
      end else begin
        ev_d       = emit_ev_c;
        ev_valid_d = 1'b1;
      end
    end else if (acc_c) begin
      ev_valid_d = 1'b0;
    end
    if (bus.start) begin
      ev_valid_d = 1'b0;
      overflow_d = 1'b0;
    end
  end

  assign bus.live_note = live_note_q;
  assign bus.ev_valid  = ev_valid_q;
  assign bus.ev_note   = ev_q.note;
  assign bus.ev_dur    = ev_q.dur;
  assign bus.ev_count  = ev_count_q;
  assign bus.done      = done_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_note_event_capture.sv
// Directed and randomized checks of note_event_capture against an elapsed-time event model.
module tb_note_event_capture;
  import note_event_capture_pkg::*;

  localparam int TICK  = 10;
  localparam int MAXEV = 100;
  localparam int DMAX  = 15;
  localparam int M_IDLE = 0, M_HOLD = 1, M_GAP = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  note_event_capture_if bus ();

  note_event_capture #(.TICK_CYCLES(TICK), .MAX_EVENTS(MAXEV), .DUR_MAX(DMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: a segment is tracked as cycles elapsed since its start.
  int m_mode, m_cur, m_since, m_note, m_dur, m_count, m_live;
  bit m_valid, m_done, m_ovf;
  int got_note[$];
  int got_dur[$];
  logic [7:0] pat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_cur = 0; m_since = 0; m_note = 0; m_dur = 0;
    m_count = 0; m_live = 0; m_valid = 0; m_done = 0; m_ovf = 0;
  endtask

  function automatic int ref_code(logic [7:0] s, logic [1:0] o);
    int oc;
    int r;
    oc = (o == 2'd0) ? 0 : ((o == 2'd2) ? 2 : 1);
    r = 0;
    for (int i = 6; i >= 0; i--) if (s[i]) r = oc * 7 + i + 1;
    return r;
  endfunction

  task automatic step();
    int code, dur, e_note, e_dur, cnt_n;
    bit emit, acc;
    code = ref_code(bus.sw, bus.octave);
    if (bus.ev_valid === 1'b1 && bus.ev_ready === 1'b1) begin
      got_note.push_back(int'(bus.ev_note));
      got_dur.push_back(int'(bus.ev_dur));
    end
    acc = m_valid && bus.ev_ready;
    emit = 0; e_note = 0; e_dur = 0;
    if (bus.en) m_live = code;
    if (bus.start) begin
      m_mode = M_IDLE; m_since = 0; m_count = 0; m_done = 0; m_ovf = 0; m_valid = 0;
    end else begin
      if (bus.en) begin
        dur = m_since / TICK;
        case (m_mode)
          M_IDLE: if (code != 0) begin m_mode = M_HOLD; m_cur = code; m_since = 0; end
          M_HOLD: if (code != m_cur) begin
              emit = 1; e_note = m_cur; e_dur = (dur < 1) ? 1 : dur;
              m_cur = code; m_since = 0;
              if (code == 0) m_mode = M_GAP;
            end else if (m_since + 1 == DMAX * TICK) begin
              emit = 1; e_note = m_cur; e_dur = DMAX; m_since = 0;
            end else m_since++;
          M_GAP: if (code != 0) begin
              if (dur >= 1) begin emit = 1; e_note = 0; e_dur = dur; end
              m_mode = M_HOLD; m_cur = code; m_since = 0;
            end else if (m_since + 1 == DMAX * TICK) begin
              emit = 1; e_note = 0; e_dur = DMAX; m_mode = M_IDLE; m_since = 0;
            end else m_since++;
          default: ;
        endcase
      end else begin
        m_since = (m_since / TICK) * TICK;
      end
      cnt_n = m_count + ((acc && m_count != MAXEV) ? 1 : 0);
      m_count = cnt_n;
      m_done = m_done || (cnt_n == MAXEV);
      if (bus.en && m_done) m_mode = M_DONE;
      if (emit) begin
        if (m_valid && !acc) m_ovf = 1;
        else begin m_valid = 1; m_note = e_note; m_dur = e_dur; end
      end else if (acc) m_valid = 0;
    end
    @(posedge clk);
    #1;
    check("ev_valid", 32'(bus.ev_valid), 32'(m_valid));
    check("live_note", 32'(bus.live_note), 32'(m_live));
    check("ev_count", 32'(bus.ev_count), 32'(m_count));
    check("done", 32'(bus.done), 32'(m_done));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    if (m_valid) begin
      check("ev_note", 32'(bus.ev_note), 32'(m_note));
      check("ev_dur", 32'(bus.ev_dur), 32'(m_dur));
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic new_take();
    bus.sw = '0; bus.start = 1'b1; step();
    bus.start = 1'b0; step();
    got_note.delete(); got_dur.delete();
  endtask

  task automatic expect_ev(input string tag, input int idx, input int note, input int dur);
    if (idx < got_note.size()) begin
      check({tag, "_note"}, 32'(got_note[idx]), 32'(note));
      check({tag, "_dur"}, 32'(got_dur[idx]), 32'(dur));
    end else begin
      check({tag, "_missing"}, 32'(got_note.size()), 32'(idx + 1));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_live_note"}, 32'(bus.live_note), 32'd0);
    check({tag, "_ev_valid"}, 32'(bus.ev_valid), 32'd0);
    check({tag, "_ev_note"}, 32'(bus.ev_note), 32'd0);
    check({tag, "_ev_dur"}, 32'(bus.ev_dur), 32'd0);
    check({tag, "_ev_count"}, 32'(bus.ev_count), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
  endtask

  initial begin
    int len;
    int mode;
    rst = 1'b0;
    bus.en = 1'b0; bus.start = 1'b0; bus.sw = '0; bus.octave = '0; bus.ev_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1; bus.en = 1'b1; bus.ev_ready = 1'b1;
    run(2);

    // 1: note, rest, note
    bus.octave = 2'd1;
    bus.sw = 8'h01; run(35);
    bus.sw = 8'h00; run(25);
    bus.sw = 8'h04; run(12);
    bus.sw = 8'h00; run(20);
    expect_ev("t1_e0", 0, 8, 3);
    expect_ev("t1_e1", 1, 0, 2);
    expect_ev("t1_e2", 2, 10, 1);
    check("t1_count", 32'(bus.ev_count), 32'd3);

    // 2: long note split at the duration cap
    new_take();
    bus.octave = 2'd2; bus.sw = 8'h40; step();
    check("t2_live", 32'(bus.live_note), 32'd21);
    run(169);
    bus.sw = 8'h00; run(5);
    expect_ev("t2_e0", 0, 21, 15);
    expect_ev("t2_e1", 1, 21, 1);

    // 3: direct key change, no rest in between
    new_take();
    bus.octave = 2'd0; bus.sw = 8'h01; run(25);
    bus.sw = 8'h02; run(15);
    bus.sw = 8'h00; run(3);
    expect_ev("t3_e0", 0, 1, 2);
    expect_ev("t3_e1", 1, 2, 1);
    check("t3_events", 32'(got_note.size()), 32'd2);

    // 4: back-pressure drops the second event
    bus.ev_ready = 1'b0;
    new_take();
    bus.octave = 2'd1; bus.sw = 8'h01; run(10);
    bus.sw = 8'h02; run(10);
    bus.sw = 8'h04; step();
    check("t4_valid", 32'(bus.ev_valid), 32'd1);
    check("t4_note", 32'(bus.ev_note), 32'd8);
    check("t4_dur", 32'(bus.ev_dur), 32'd1);
    check("t4_overflow", 32'(bus.overflow), 32'd1);
    bus.ev_ready = 1'b1; step();
    check("t4_count", 32'(bus.ev_count), 32'd1);
    check("t4_drained", 32'(bus.ev_valid), 32'd0);

    // 5: fill the take, then keys are ignored until start
    new_take();
    bus.octave = 2'd0;
    for (int k = 0; k < 100; k++) begin
      pat = 8'h01;
      bus.sw = 8'(pat << (k % 7)); run(4);
      bus.sw = 8'h00; run(3);
    end
    run(3);
    check("t5_done", 32'(bus.done), 32'd1);
    check("t5_count", 32'(bus.ev_count), 32'd100);
    bus.sw = 8'h08; run(30);
    bus.sw = 8'h00; run(5);
    check("t5_ignored_count", 32'(bus.ev_count), 32'd100);
    check("t5_ignored_valid", 32'(bus.ev_valid), 32'd0);
    bus.start = 1'b1; step();
    bus.start = 1'b0;
    check("t5_restart_count", 32'(bus.ev_count), 32'd0);
    check("t5_restart_done", 32'(bus.done), 32'd0);
    run(2);

    // 6: asynchronous reset with an event pending
    new_take();
    bus.ev_ready = 1'b0;
    bus.octave = 2'd1; bus.sw = 8'h01; run(12);
    bus.sw = 8'h02; step();
    check("t6_pending", 32'(bus.ev_valid), 32'd1);
    rst = 1'b0;
    #1;
    check_all_zero("t6_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b1; bus.ev_ready = 1'b1;
    got_note.delete(); got_dur.delete();
    step();
    check("t6_live", 32'(bus.live_note), 32'd9);
    run(20);
    bus.sw = 8'h00; run(3);
    expect_ev("t6_e0", 0, 9, 2);

    // Random keys, octave, ready, enable and occasional start
    new_take();
    pat = 8'h00;
    for (int seg = 0; seg < 120; seg++) begin
      mode = int'($urandom_range(0, 3));
      case (mode)
        0: pat = 8'h00;
        1: pat = 8'(32'd1 << $urandom_range(0, 7));
        2: pat = 8'($urandom);
        default: ;
      endcase
      bus.sw = pat;
      bus.octave = 2'($urandom_range(0, 3));
      len = int'($urandom_range(1, ($urandom_range(0, 7) == 0) ? 200 : 40));
      for (int c = 0; c < len; c++) begin
        bus.ev_ready = ($urandom_range(0, 9) != 0);
        bus.en       = ($urandom_range(0, 29) != 0);
        bus.start    = ($urandom_range(0, 499) == 0);
        step();
      end
    end
    bus.start = 1'b0; bus.en = 1'b1; bus.ev_ready = 1'b1; bus.sw = 8'h00;
    run(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
